mont_mul_ws: RTL and testbench



---
 rtl/mont_mul_ws.sv | 133 +++++++++++++
 tb/tb_mont_mul_ws.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_ws.sv
// Word-serial Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^(W*S).
// One W-bit word of a is consumed per outer iteration, in three cycles:
// accumulate a_i*b, derive the reduction digit m, then add m*n and shift.
module mont_mul_ws #(
  parameter int NBITS = 1024,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  input  logic [W-1:0]     n0prime,
  output logic [NBITS-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int S  = NBITS / W;
  // Two guard bits above NBITS+W keep T + a_i*b + m*n from overflowing.
  localparam int TW = NBITS + W + 2;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_AB,
    ST_CALC_M,
    ST_REDUCE,
    ST_FINAL_SUB,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] n_q;
  logic [W-1:0]     np_q;
  logic [W-1:0]     m_q;
  logic [TW-1:0]    t_q;
  logic [IW-1:0]    i_q;
  logic [W-1:0]     a_word;
  logic             last_word;

  assign a_word    = a_q[i_q*W +: W];
  assign last_word = (i_q == IW'(S - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and status outputs; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_MUL_AB;
      end
      ST_MUL_AB: begin
        busy      = 1'b1;
        state_nxt = ST_CALC_M;
      end
      ST_CALC_M: begin
        busy      = 1'b1;
        state_nxt = ST_REDUCE;
      end
      ST_REDUCE: begin
        busy      = 1'b1;
        state_nxt = last_word ? ST_FINAL_SUB : ST_MUL_AB;
      end
      ST_FINAL_SUB: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, accumulator and word index, final conditional subtract.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      np_q   <= '0;
      m_q    <= '0;
      t_q    <= '0;
      i_q    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            n_q  <= n;
            np_q <= n0prime;
            t_q  <= '0;
            i_q  <= '0;
          end
        end
        ST_MUL_AB: begin
          t_q <= t_q + TW'(a_word) * TW'(b_q);
        end
        ST_CALC_M: begin
          m_q <= t_q[W-1:0] * np_q;
        end
        ST_REDUCE: begin
          // m is chosen so the low W bits of the sum are zero; shifting drops them.
          t_q <= (t_q + TW'(m_q) * TW'(n_q)) >> W;
          if (!last_word) i_q <= i_q + IW'(1);
        end
        ST_FINAL_SUB: begin
          // T < 2n here, so T-n fits in NBITS bits and modular low-bit subtraction is exact.
          if (t_q >= TW'(n_q)) result <= t_q[NBITS-1:0] - n_q;
          else                 result <= t_q[NBITS-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ws.sv
// Bench for mont_mul_ws: 64-bit directed vectors and 1024-bit random vectors
// against an independent bit-serial Montgomery reference model.
module tb_mont_mul_ws;

  localparam int NS = 64;
  localparam int NL = 1024;
  localparam logic [63:0] N64  = 64'hFFFFFFFFFFFFFFC5;
  localparam logic [31:0] NP64 = 32'hA08AD8F3;
  localparam logic [63:0] BV   = 64'h123456789ABCDEF0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          s64, d64, bz64;
  logic [NS-1:0] a64, b64, n64, r64;
  logic [31:0]   np64;

  logic          s1k, d1k, bz1k;
  logic [NL-1:0] a1k, b1k, n1k, r1k;
  logic [31:0]   np1k;

  mont_mul_ws #(.NBITS(NS), .W(32)) dut64 (
    .clk(clk), .reset(reset), .start(s64), .a(a64), .b(b64), .n(n64),
    .n0prime(np64), .result(r64), .done(d64), .busy(bz64)
  );

  mont_mul_ws #(.NBITS(NL), .W(32)) dut1k (
    .clk(clk), .reset(reset), .start(s1k), .a(a1k), .b(b1k), .n(n1k),
    .n0prime(np1k), .result(r1k), .done(d1k), .busy(bz1k)
  );

  int tests = 0;
  int fails = 0;

  logic [NS-1:0] q64[$];
  logic [NL-1:0] q1k[$];

  typedef struct {
    logic [NS-1:0] a;
    logic [NS-1:0] b;
    logic [NS-1:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [NL-1:0] act, input logic [NL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h (low 128b) expected %h (low 128b)", nm, act[127:0], exp[127:0]);
    end
  endtask

  // a*b*2^-NL mod n, one bit of reduction at a time.
  function automatic logic [NL-1:0] mont_ref(input logic [NL-1:0] a, input logic [NL-1:0] b,
                                             input logic [NL-1:0] n);
    logic [2*NL+1:0] x;
    x = {2'b0, NL'(0), a} * {2'b0, NL'(0), b};
    for (int k = 0; k < NL; k++) begin
      if (x[0]) x = x + {(NL+2)'(0), n};
      x = x >> 1;
    end
    if (x >= {(NL+2)'(0), n}) x = x - {(NL+2)'(0), n};
    return x[NL-1:0];
  endfunction

  // -n^-1 mod 2^32 by Newton iteration (the n0prime stage's job).
  function automatic logic [31:0] n0p(input logic [31:0] n0);
    logic [31:0] x;
    x = 32'd1;
    for (int k = 0; k < 6; k++) x = x * (32'd2 - n0 * x);
    return -x;
  endfunction

  function automatic logic [NL-1:0] rnd1k();
    logic [NL-1:0] v;
    for (int w = 0; w < NL/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // One 64-bit operation with latency, busy-length and scoreboard checks.
  task automatic go64(input logic [NS-1:0] a, input logic [NS-1:0] b, input logic [NS-1:0] exp,
                      input string nm);
    int lat, bcnt;
    a64 = a; b64 = b; n64 = N64; np64 = NP64;
    s64 = 1'b1;
    q64.push_back(exp);
    @(posedge clk); #1;
    s64 = 1'b0;
    bcnt = bz64 ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (d64) begin
        lat = k;
        break;
      end
      if (bz64) bcnt++;
    end
    if (lat < 0) begin
      chk({nm, "_timeout"}, 0, 1);
      void'(q64.pop_front());
    end else begin
      chk({nm, "_result"}, NL'(r64), NL'(q64.pop_front()));
      chk({nm, "_latency"}, NL'(lat), NL'(7));
      chk({nm, "_busy_cycles"}, NL'(bcnt), NL'(7));
      chk({nm, "_busy_at_done"}, NL'(bz64), NL'(0));
      @(posedge clk); #1;
      chk({nm, "_done_one_cycle"}, NL'(d64), NL'(0));
    end
  endtask

  vec_t tbl[4];

  initial begin
    int pulses, lat;
    logic [NL-1:0] ra, rb, rn, ex;

    reset = 1'b1;
    s64 = 0; a64 = '0; b64 = '0; n64 = N64; np64 = NP64;
    s1k = 0; a1k = '0; b1k = '0; n1k = '0; np1k = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_result", NL'(r64), 0);
    chk("reset_done", NL'(d64), 0);
    chk("reset_busy", NL'(bz64), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: 59 is R mod n, so a=59 returns b unchanged.
    tbl[0] = '{a: 64'd59,    b: BV,       exp: BV};
    tbl[1] = '{a: 64'd59,    b: 64'd59,   exp: 64'd59};
    tbl[2] = '{a: 64'd0,     b: 64'h123,  exp: 64'd0};
    tbl[3] = '{a: N64 - 1,   b: 64'd59,   exp: 64'hFFFFFFFFFFFFFFC4};
    for (int v = 0; v < 4; v++) go64(tbl[v].a, tbl[v].b, tbl[v].exp, $sformatf("vec%0d", v));

    // Start re-pulsed mid-operation with a different a must be ignored.
    a64 = 64'd59; b64 = BV; n64 = N64; np64 = NP64;
    s64 = 1'b1;
    q64.push_back(BV);
    @(posedge clk); #1;
    s64 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s64 = 1'b1; a64 = N64 - 1;
    @(posedge clk); #1;
    s64 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (d64) begin
        pulses++;
        if (q64.size() > 0) chk("ignored_start_result", NL'(r64), NL'(q64.pop_front()));
        else chk("ignored_start_extra_done", 0, 1);
      end
      @(posedge clk); #1;
    end
    chk("ignored_start_pulses", NL'(pulses), NL'(1));
    chk("scoreboard_empty", NL'(q64.size()), 0);

    // Reset mid-operation discards the work and never pulses done.
    a64 = N64 - 1; b64 = 64'd59;
    s64 = 1'b1;
    @(posedge clk); #1;
    s64 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("midreset_result", NL'(r64), 0);
    chk("midreset_busy", NL'(bz64), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (d64) pulses++;
    end
    chk("midreset_no_done", NL'(pulses), 0);
    go64(64'd59, BV, BV, "after_reset");

    // 1024-bit random operands with a bench-side n0prime.
    for (int t = 0; t < 200; t++) begin
      rn = rnd1k();
      rn[NL-1] = 1'b1;
      rn[0] = 1'b1;
      ra = rnd1k() % rn;
      rb = rnd1k() % rn;
      ex = mont_ref(ra, rb, rn);
      a1k = ra; b1k = rb; n1k = rn; np1k = n0p(rn[31:0]);
      s1k = 1'b1;
      q1k.push_back(ex);
      @(posedge clk); #1;
      s1k = 1'b0;
      lat = -1;
      for (int k = 1; k <= 120; k++) begin
        @(posedge clk); #1;
        if (d1k) begin
          lat = k;
          break;
        end
      end
      if (lat < 0) begin
        chk($sformatf("rand%0d_timeout", t), 0, 1);
        void'(q1k.pop_front());
      end else begin
        chk($sformatf("rand%0d_result", t), r1k, q1k.pop_front());
        chk($sformatf("rand%0d_latency", t), NL'(lat), NL'(97));
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
